// File: rtl/dmem_lsu.sv
// Load/store unit: byte-addressed core requests to a word-wide single-port data memory.
// Latency: SW and error requests respond 1 cycle after accept; loads and SB/SH respond after 2.
// Backpressure: req_ready is low while a load or sub-word store is in flight (one cycle each).
module dmem_lsu #(
    parameter int DATA_WIDTH = 32,  // fixed at 32; lane slicing below assumes it
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_error,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [1:0] IDLE        = 2'b00;
    localparam logic [1:0] LOAD_WAIT   = 2'b01;
    localparam logic [1:0] STORE_MERGE = 2'b10;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] lat_index;
    logic [1:0]            lat_lane;
    logic [1:0]            lat_size;
    logic                  lat_unsigned;
    logic [15:0]           lat_wdata;

    logic                  accept;
    logic                  req_bad;
    logic                  req_sw;
    logic [ADDR_WIDTH-1:0] req_index;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [DATA_WIDTH-1:0] ld_result;
    logic [DATA_WIDTH-1:0] merge_word;

    // Address bits above the memory's reach are dropped, so addresses wrap.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH+2];

    assign req_index = req_addr[ADDR_WIDTH+1:2];
    assign req_ready = (state == IDLE) && rst_n;
    assign accept    = req_valid && req_ready;
    assign req_sw    = req_write && (req_size == SIZE_W);

    // Misalignment and illegal size detection; such requests never touch memory.
    always_comb begin
        req_bad = 1'b0;
        case (req_size)
            SIZE_B:  req_bad = 1'b0;
            SIZE_H:  req_bad = req_addr[0];
            SIZE_W:  req_bad = (req_addr[1:0] != 2'b00);
            default: req_bad = 1'b1;
        endcase
    end

    // Memory port: merge cycle replays the latched index, otherwise the request address drives it.
    // mem_we is gated by rst_n so an in-flight merge write dies the moment reset asserts.
    always_comb begin
        mem_addr  = req_index;
        mem_wdata = req_wdata;
        mem_we    = 1'b0;
        if (state == STORE_MERGE) begin
            mem_addr  = lat_index;
            mem_wdata = merge_word;
            mem_we    = rst_n;
        end else if (accept && req_sw && !req_bad) begin
            mem_we    = 1'b1;
        end
    end

    // Load lane selection and sign/zero extension from the word returned by memory.
    always_comb begin
        ld_byte = 8'h00;
        case (lat_lane)
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = lat_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (lat_size)
            SIZE_B:  ld_result = {{24{ld_byte[7] & ~lat_unsigned}}, ld_byte};
            SIZE_H:  ld_result = {{16{ld_half[15] & ~lat_unsigned}}, ld_half};
            default: ld_result = mem_rdata;
        endcase
    end

    // Read-modify-write merge: replace only the target byte/half of the word just read.
    always_comb begin
        merge_word = mem_rdata;
        if (lat_size == SIZE_B) begin
            case (lat_lane)
                2'd0:    merge_word[7:0]   = lat_wdata[7:0];
                2'd1:    merge_word[15:8]  = lat_wdata[7:0];
                2'd2:    merge_word[23:16] = lat_wdata[7:0];
                default: merge_word[31:24] = lat_wdata[7:0];
            endcase
        end else if (lat_lane[1]) begin
            merge_word[31:16] = lat_wdata;
        end else begin
            merge_word[15:0]  = lat_wdata;
        end
    end

    // State sequencing and latching of the request fields needed in the second cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            lat_index    <= '0;
            lat_lane     <= 2'b00;
            lat_size     <= 2'b00;
            lat_unsigned <= 1'b0;
            lat_wdata    <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && !req_bad && !req_sw) begin
                        lat_index    <= req_index;
                        lat_lane     <= req_addr[1:0];
                        lat_size     <= req_size;
                        lat_unsigned <= req_unsigned;
                        lat_wdata    <= req_wdata[15:0];
                        state        <= req_write ? STORE_MERGE : LOAD_WAIT;
                    end
                end
                LOAD_WAIT:   state <= IDLE;
                STORE_MERGE: state <= IDLE;
                default:     state <= IDLE;
            endcase
        end
    end

    // Response register: one-cycle pulse per accepted request; rdata is zero unless a load completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid <= 1'b0;
            resp_error <= 1'b0;
            resp_rdata <= '0;
        end else begin
            resp_valid <= 1'b0;
            resp_error <= 1'b0;
            resp_rdata <= '0;
            case (state)
                IDLE: begin
                    if (accept && req_bad) begin
                        resp_valid <= 1'b1;
                        resp_error <= 1'b1;
                    end else if (accept && req_sw) begin
                        resp_valid <= 1'b1;
                    end
                end
                LOAD_WAIT: begin
                    resp_valid <= 1'b1;
                    resp_rdata <= ld_result;
                end
                STORE_MERGE: resp_valid <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Randomized plus directed bench for dmem_lsu with a scoreboard queue and a word-array reference model.
// Latency: responses are checked against the cycle number the model predicts.
// Backpressure: the driver holds req_valid until req_ready, with a bounded wait.
module tb_dmem_lsu;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    dmem_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_error(resp_error), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Data memory: registered read address, write lands at the clock edge.
    logic [31:0] sram [1024];
    logic [9:0]  rd_addr;
    logic        sram_clr;
    always @(posedge clk) begin
        if (sram_clr) begin
            for (int i = 0; i < 1024; i++) sram[i] <= 32'h0;
        end else if (mem_we) begin
            sram[mem_addr] <= mem_wdata;
        end
        rd_addr <= mem_addr;
    end
    assign mem_rdata = sram[rd_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int we_cnt = 0;
    always @(negedge clk) if (mem_we) we_cnt <= we_cnt + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          at_cyc;
    } exp_t;
    exp_t expq[$];

    logic [31:0] model_mem [1024];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every response must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (resp_valid) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp actual=resp_valid expected=no response (cyc %0d)", cyc);
            end else begin
                e = expq.pop_front();
                check("resp_cycle", cyc, e.at_cyc);
                check("resp_rdata", resp_rdata, e.rdata);
                check("resp_error", 32'(resp_error), 32'(e.err));
            end
        end
    end

    function automatic logic [31:0] load_val(input logic [31:0] w, input logic [1:0] sz,
                                            input int lane, input logic uns);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (w >> (8 * lane)) & 32'hFF;
            if (!uns && v >= 32'h80) v = v + 32'hFFFFFF00;
        end else if (sz == 2'd1) begin
            v = (w >> (8 * lane)) & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v + 32'hFFFF0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] store_val(input logic [31:0] w, input logic [1:0] sz,
                                             input int lane, input logic [31:0] wd);
        logic [31:0] mask;
        mask = (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFFFFFF;
        return (w & ~(mask << (8 * lane))) | ((wd & mask) << (8 * lane));
    endfunction

    // Present a request, wait (bounded) for acceptance, then record the model's expectation.
    task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd, output int waited);
        exp_t        e;
        logic [9:0]  idx;
        int          lane;
        logic        bad;
        req_valid    = 1'b1;
        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        waited       = 0;
        while (!req_ready && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=req_ready low expected=accept within 20 cycles");
            req_valid = 1'b0;
        end else begin
            idx  = 10'((addr >> 2) % 1024);
            lane = int'(addr % 4);
            bad  = (sz == 2'd3) || (sz == 2'd1 && addr % 2 != 0) || (sz == 2'd2 && addr % 4 != 0);
            e.err   = bad;
            e.rdata = 32'h0;
            if (bad) begin
                e.at_cyc = cyc + 1;
            end else if (wr) begin
                model_mem[idx] = store_val(model_mem[idx], sz, lane, wd);
                e.at_cyc = cyc + ((sz == 2'd2) ? 1 : 2);
            end else begin
                e.rdata  = load_val(model_mem[idx], sz, lane, uns);
                e.at_cyc = cyc + 2;
            end
            expq.push_back(e);
            @(posedge clk);
            #1;
            req_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (expq.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (expq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d pending expected=0", expq.size());
            expq.delete();
        end
    endtask

    initial begin
        int w;
        int w2;
        int we_base;
        int mism;
        logic [31:0] a;
        logic [1:0]  sz;

        for (int i = 0; i < 1024; i++) model_mem[i] = 32'h0;
        rst_n = 1'b0; sram_clr = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        sram_clr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_req_ready", 32'(req_ready), 32'h1);
        check("idle_resp_valid", 32'(resp_valid), 32'h0);
        check("idle_resp_rdata", resp_rdata, 32'h0);
        check("idle_mem_we", 32'(mem_we), 32'h0);

        // SW then LW to the same word
        issue(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, w);
        check("sw_word40", sram[10'h040], 32'hDEADBEEF);
        issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, w);

        // SB into top byte, then signed and unsigned byte loads
        issue(1'b1, 2'd2, 1'b0, 32'h100, 32'h11223344, w);
        issue(1'b1, 2'd0, 1'b0, 32'h103, 32'h000000A5, w);
        issue(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, w);
        check("sb_word40", sram[10'h040], 32'hA5223344);
        issue(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, w);

        // SH into upper half, then signed and unsigned half loads
        issue(1'b1, 2'd2, 1'b0, 32'h100, 32'h0, w);
        issue(1'b1, 2'd1, 1'b0, 32'h102, 32'h12348001, w);
        issue(1'b0, 2'd1, 1'b0, 32'h102, 32'h0, w);
        check("sh_word40", sram[10'h040], 32'h80010000);
        issue(1'b0, 2'd1, 1'b1, 32'h102, 32'h0, w);

        // Misaligned and illegal requests: no memory writes
        drain();
        we_base = we_cnt;
        issue(1'b0, 2'd2, 1'b0, 32'h101, 32'h0, w);
        issue(1'b1, 2'd1, 1'b0, 32'h103, 32'hFFFFFFFF, w);
        issue(1'b1, 2'd3, 1'b0, 32'h100, 32'hFFFFFFFF, w);
        drain();
        check("err_no_we", we_cnt - we_base, 32'h0);
        check("err_word40", sram[10'h040], 32'h80010000);

        // Back-to-back SB then LW with req_valid held
        issue(1'b1, 2'd2, 1'b0, 32'h200, 32'hFFFFFFFF, w);
        issue(1'b1, 2'd0, 1'b0, 32'h200, 32'h0000007F, w);
        issue(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, w2);
        check("merge_ready_low_cycles", w2, 32'd1);
        drain();
        check("b2b_word80", sram[10'h080], 32'hFFFFFF7F);

        // Reset asserted during STORE_MERGE
        issue(1'b1, 2'd2, 1'b0, 32'h300, 32'h55667788, w);
        drain();
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 32'h300; req_wdata = 32'h00000099;
        check("pre_abort_ready", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = 32'h0;
        check("merge_we", 32'(mem_we), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check("abort_mem_we", 32'(mem_we), 32'h0);
        check("abort_req_ready", 32'(req_ready), 32'h0);
        check("abort_resp_valid", 32'(resp_valid), 32'h0);
        check("abort_resp_error", 32'(resp_error), 32'h0);
        check("abort_resp_rdata", resp_rdata, 32'h0);
        @(posedge clk);
        #1;
        check("abort_wordC0", sram[10'h0C0], 32'h55667788);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release_req_ready", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;

        // Randomized traffic over a few words with random upper address bits
        for (int k = 0; k < 400; k++) begin
            a  = $urandom() & 32'hFFFF_F01F;
            sz = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 15) == 0) sz = 2'd3;
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom(), w);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        drain();

        mism = 0;
        for (int i = 0; i < 1024; i++) if (sram[i] !== model_mem[i]) mism++;
        check("final_mem_image", mism, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Load/store unit between the core's memory stage and the word-wide, single-port data memory.
- The data memory has a registered read address and no byte enables. Read data for an address presented in cycle N is valid in cycle N+1.
- Translates byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses.
- Sub-word stores use read-modify-write. Load results are lane-extracted and sign/zero-extended. Misaligned accesses are flagged and never touch memory.

Parameters:
- DATA_WIDTH, 32, word width; fixed at 32, other values unsupported.
- ADDR_WIDTH, 10, data memory word-index width; the memory holds 2**ADDR_WIDTH words.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  core request present.
- req_ready  out  1  unit can accept a request this cycle.
- req_write  in  1  1=store, 0=load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  zero-extend loads (LBU/LHU); ignored for stores and word loads.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the payload is in the low byte or half.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_error  out  1  misaligned or illegal size; valid with resp_valid.
- mem_addr  out  ADDR_WIDTH  word index to data memory.
- mem_wdata  out  32  write word.
- mem_we  out  1  write enable.
- mem_rdata  in  32  memory read data, valid one cycle after address.

Behaviour:
- Addressing:
  - Word index = req_addr[ADDR_WIDTH+1:2]. Upper address bits are ignored, so addresses wrap.
  - Byte lane = addr[1:0], little-endian. Half lane = addr[1].
- Alignment check:
  - Half requires addr[0]=0. Word requires addr[1:0]=00. Size 11 is always an error.
- States: IDLE, LOAD_WAIT, STORE_MERGE.
  - req_ready=1 only in IDLE with rst_n high.
- IDLE, accepting when req_valid=1, cycle 0:
  - Error request: no memory write. Registered resp_valid=1, resp_error=1, resp_rdata=0 in cycle 1. Stay in IDLE.
  - SW: mem_addr=index, mem_wdata=req_wdata, mem_we=1, all combinational in cycle 0. resp_valid in cycle 1. Stay in IDLE.
  - Load: mem_addr=index. Latch addr[1:0], size and unsigned. Go to LOAD_WAIT.
  - SB/SH: mem_addr=index. Latch index, lane, size and wdata. Go to STORE_MERGE.
- LOAD_WAIT, cycle 1:
  - Select lane from mem_rdata and extend: sign from bit 7/15, or zero if unsigned.
  - Register the result into resp_rdata and pulse resp_valid in cycle 2. Return to IDLE.
- STORE_MERGE, cycle 1:
  - mem_addr = latched index.
  - mem_wdata = mem_rdata with the target byte/half replaced by the low byte/half of the latched wdata. mem_we=1.
  - resp_valid in cycle 2. Return to IDLE.
- Latency: SW and errors 1 cycle; loads and sub-word stores 2 cycles.
- Back-to-back: IDLE is re-entered in the resp_valid cycle, so a new request may be accepted in that same cycle.
  - A load following a store to the same word returns the merged/written value. The write lands at the edge before the read address is sampled.
- No request in IDLE: mem_we=0. mem_addr follows req_addr (don't-care).
- resp_valid is exactly one cycle per accepted request, never two consecutive without an intervening accept.
- Reset (async, including mid-operation):
  - State = IDLE. resp_valid=0, resp_error=0, resp_rdata=0, latches=0.
  - mem_we=0 and req_ready=0 while rst_n=0, gated combinationally so an in-flight merge write is suppressed immediately.
  - An aborted request produces no response.

Test Plan:
1. SW 0xDEADBEEF @0x100, then LW @0x100 -> store resp_valid at accept+1; mem word 0x40 = 0xDEADBEEF; load resp_rdata=0xDEADBEEF at accept+2, resp_error=0.
2. Word 0x40 preset 0x11223344; SB 0x000000A5 @0x103 -> word=0xA5223344. LB @0x103 -> 0xFFFFFFA5. LBU @0x103 -> 0x000000A5.
3. Word preset 0; SH 0x12348001 @0x102 -> word=0x80010000. LH @0x102 -> 0xFFFF8001. LHU -> 0x00008001.
4. LW @0x101, SH @0x103, size=11 @0x100 -> each gives resp_valid+resp_error=1 at accept+1, resp_rdata=0, mem_we never high, memory unchanged.
5. req_valid held: SB 0x7F @0x200 then LW @0x200 (word preset 0xFFFFFFFF) -> req_ready low exactly one cycle during merge; LW accepted in the SB resp cycle returns 0xFFFFFF7F.
6. Assert rst_n=0 during STORE_MERGE -> mem_we drops the same cycle, target word unchanged, all outputs 0, no response; req_ready=1 the first cycle after release.
